// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding and
// the width of the bits-remaining counter.
package word_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Bits needed to hold (width-1); never narrower than one bit.
   function automatic int count_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/word_shift_reg.sv
// WIDTH-bit parallel-load register that shifts one position per enable,
// zero-filling, towards the serial output end chosen by MSB_FIRST.
module word_shift_reg
   import word_serializer_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             nrst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             bit_o
);

   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;

   // Load wins over shift so a reload on the final beat replaces the old word.
   always_comb begin
      sreg_d = sreg_q;
      if (load_i) begin
         sreg_d = data_i;
      end else if (shift_i) begin
         sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                            : {1'b0, sreg_q[WIDTH-1:1]};
      end
   end

   // Storage with asynchronous clear.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign bit_o = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, serial-out converter. Accepts a WIDTH-bit word over a
// valid/ready port and drains it one bit per accepted beat. The only
// combinational path is out_ready -> in_ready, which lets a new word be
// loaded on the final beat of the previous one without an idle cycle.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             nrst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   localparam int            CW       = count_width(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   state_e        state_q;
   logic [CW-1:0] count_q;   // bits remaining minus one
   logic          last_q;    // registered copy of (SHIFT && count_q == 0)
   logic          count_zero;
   logic          accept;
   logic          shift_en;
   logic          sreg_bit;

   assign count_zero = (count_q == '0);
   assign in_ready   = (state_q == IDLE) ||
                       ((state_q == SHIFT) && count_zero && out_ready);
   assign accept     = in_valid && in_ready;
   assign shift_en   = (state_q == SHIFT) && out_ready && !count_zero;

   // FSM: tracks word in flight, bits remaining and the last-bit flag.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         count_q <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= SHIFT;
                  count_q <= LAST_IDX;
                  last_q  <= 1'b0;
               end
            end
            SHIFT: begin
               if (out_ready) begin
                  if (!count_zero) begin
                     count_q <= count_q - CW'(1);
                     last_q  <= (count_q == CW'(1));
                  end else if (accept) begin
                     count_q <= LAST_IDX;
                     last_q  <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     last_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               count_q <= '0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   word_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_reg (
      .CLK     (CLK),
      .nrst    (nrst),
      .load_i  (accept),
      .shift_i (shift_en),
      .data_i  (in_data),
      .bit_o   (sreg_bit)
   );

   // Outputs come from registers only; the stale bit left after a word
   // completes is masked while idle.
   assign out_valid = (state_q == SHIFT);
   assign busy      = (state_q == SHIFT);
   assign out_last  = last_q;
   assign out_bit   = sreg_bit & (state_q == SHIFT);

endmodule
